pe_result_collector: RTL and testbench

- Sits directly downstream of the last PE in a chain and consumes its O_DataOut/O_DataOutValid stream.
- Drives that PE's O_DataOutRdy using credit-style slot reservation. A result issued into the PE's MAC pipeline is therefore never lost, even though it emerges Pipeline_Stages cycles later.
- Buffers results in a show-ahead FIFO, re-emits them on a valid/ready stream, counts them against a programmed tile length, and pulses Done when the tile is fully drained.

---
 rtl/pe_result_collector.sv | 137 +++++++++++++
 tb/tb_pe_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Collects results from the last PE of a chain, reserving a FIFO slot for every
// PE_DataInRdy cycle so in-flight MAC results always have somewhere to land.
module pe_result_collector #(
  parameter int DataWidth       = 32,
  parameter int BufferWidth     = 4,
  parameter int BufferSize      = 16,
  parameter int Pipeline_Stages = 12,
  parameter int CountWidth      = 16
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  Start,
  input  logic [CountWidth-1:0] Len,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  input  logic [DataWidth-1:0]  PE_DataIn,
  input  logic                  PE_DataInValid,
  output logic                  PE_DataInRdy,
  output logic [DataWidth-1:0]  DataOut,
  output logic                  DataOutValid,
  input  logic                  DataOutRdy
);

  localparam int IW   = $clog2(Pipeline_Stages + 1);
  localparam int OW   = BufferWidth + 1;
  localparam int SUMW = ((OW > IW) ? OW : IW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [OW-1:0]              occ_q, occ_d;
  logic [IW-1:0]              inflight_q, inflight_d;
  logic [Pipeline_Stages-1:0] resv_q, resv_d;
  logic [BufferWidth-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0]      recv_q, recv_d, len_q, len_d;
  logic                       err_q, err_d, done_q, done_d;
  logic [DataWidth-1:0]       mem [BufferSize];

  logic [SUMW-1:0] committed;
  logic            expiring, empty, full, pop, push, active, cnt_ok, err_evt;

  // Committed slots: words already buffered plus results the PE may still deliver.
  assign committed    = SUMW'(occ_q) + SUMW'(inflight_q);
  assign PE_DataInRdy = (state_q == S_COLLECT) && (committed < SUMW'(BufferSize));
  assign expiring     = resv_q[Pipeline_Stages-1];
  assign empty        = (occ_q == '0);
  assign full         = (occ_q == OW'(BufferSize));
  assign pop          = !empty && DataOutRdy;
  assign active       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign cnt_ok       = (recv_q < len_q);
  assign push         = PE_DataInValid && active && cnt_ok && (!full || pop);
  assign err_evt      = PE_DataInValid && (!cnt_ok || (full && !pop) || !expiring);

  assign Busy         = (state_q != S_IDLE);
  assign Done         = done_q;
  assign Err          = err_q;
  assign DataOutValid = !empty;
  assign DataOut      = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    resv_d     = {resv_q[Pipeline_Stages-2:0], PE_DataInRdy};
    inflight_d = inflight_q + IW'(PE_DataInRdy) - IW'(expiring);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    recv_d  = push ? recv_q + CountWidth'(1) : recv_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            len_d   = Len;
            recv_d  = '0;
            err_d   = 1'b0;
            state_d = S_COLLECT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (push && (recv_q + CountWidth'(1) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Outstanding reservations must retire so a late result is never orphaned.
        if (empty && (inflight_q == '0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_evt) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      inflight_q <= '0;
      resv_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      recv_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      resv_q     <= resv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      recv_q     <= recv_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= PE_DataIn;
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector with a 12-cycle model PE on the input side.
module tb_pe_result_collector;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Len = '0;
  logic        Busy, Done, Err, PE_DataInRdy, DataOutValid;
  logic [31:0] PE_DataIn = '0;
  logic        PE_DataInValid = 1'b0;
  logic [31:0] DataOut;
  logic        DataOutRdy = 1'b0;

  pe_result_collector dut (
    .clk(clk), .aclr(aclr), .Start(Start), .Len(Len),
    .Busy(Busy), .Done(Done), .Err(Err),
    .PE_DataIn(PE_DataIn), .PE_DataInValid(PE_DataInValid), .PE_DataInRdy(PE_DataInRdy),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutRdy(DataOutRdy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  bit          sched_v [16];
  logic [31:0] sched_d [16];
  int          cyc = 0;
  int          issued = 0;
  int          issue_lim = 0;
  int          push_lim = 0;
  logic [31:0] base = '0;
  bit          pe_en = 1'b0;
  bit          chk_lat = 1'b0;
  bit          pv_prev = 1'b0;
  logic [31:0] pd_prev = '0;
  int          d0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (aclr && DataOutValid && DataOutRdy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL pop_extra: got %h with no word expected", DataOut);
        end else begin
          e = exp_q.pop_front();
          if (DataOut !== e) begin
            n_mis++;
            $display("FAIL pop_data: got %h required %h", DataOut, e);
          end
        end
      end
      if (Done) done_cnt++;
    end
  end

  // One cycle: model PE delivers what it issued 12 cycles ago, then issues on ready.
  task automatic tick();
    int slot;
    @(posedge clk);
    #1;
    if (chk_lat && pv_prev) begin
      check("lat_vld", {31'd0, DataOutValid}, 32'd1);
      check("lat_dat", DataOut, pd_prev);
    end
    cyc++;
    slot = cyc % 16;
    PE_DataInValid = sched_v[slot];
    PE_DataIn = sched_v[slot] ? sched_d[slot] : 32'h0;
    sched_v[slot] = 1'b0;
    pv_prev = PE_DataInValid;
    pd_prev = PE_DataIn;
    if (pe_en && PE_DataInRdy && issued < issue_lim) begin
      sched_v[(cyc + 12) % 16] = 1'b1;
      sched_d[(cyc + 12) % 16] = base + issued;
      if (issued < push_lim) exp_q.push_back(base + issued);
      issued++;
    end
  endtask

  task automatic start_tile(input logic [15:0] l, input logic [31:0] b, input int ilim, input int plim);
    base = b; issue_lim = ilim; push_lim = plim; issued = 0; pe_en = 1'b1;
    Start = 1'b1; Len = l;
    tick();
    Start = 1'b0; Len = '0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 300 && Busy; k++) tick();
    check(nm, {31'd0, Busy}, 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin sched_v[i] = 1'b0; sched_d[i] = '0; end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err",  {31'd0, Err}, 32'd0);
    check("rst_rdy",  {31'd0, PE_DataInRdy}, 32'd0);
    check("rst_dov",  {31'd0, DataOutValid}, 32'd0);
    check("rst_dout", DataOut, 32'd0);
    aclr = 1'b1;
    repeat (2) tick();

    // Tile of 4, consumer always ready
    DataOutRdy = 1'b1; chk_lat = 1'b1; d0 = done_cnt;
    start_tile(16'd4, 32'h10, 4, 4);
    check("t1_busy", {31'd0, Busy}, 32'd1);
    wait_idle("t1_idle");
    chk_lat = 1'b0;
    check("t1_done", done_cnt - d0, 32'd1);
    check("t1_err",  {31'd0, Err}, 32'd0);
    check("t1_left", exp_q.size(), 32'd0);

    // Tile of 40 with a stalled consumer: reservations cap at 16
    DataOutRdy = 1'b0; d0 = done_cnt;
    start_tile(16'd40, 32'h100, 39, 39);
    repeat (40) tick();
    check("t2_issued", issued, 32'd16);
    check("t2_rdy",    {31'd0, PE_DataInRdy}, 32'd0);
    check("t2_err",    {31'd0, Err}, 32'd0);
    check("t2_head",   DataOut, 32'h100);

    // Unreserved word pushed into the full FIFO on a popping cycle
    PE_DataInValid = 1'b1; PE_DataIn = 32'hBEEF; DataOutRdy = 1'b1;
    exp_q.push_back(32'hBEEF);
    tick();
    DataOutRdy = 1'b0;
    check("t3_full_rdy", {31'd0, PE_DataInRdy}, 32'd0);
    check("t3_err",      {31'd0, Err}, 32'd1);
    tick();
    check("t3_hold_rdy", {31'd0, PE_DataInRdy}, 32'd0);
    DataOutRdy = 1'b1;
    wait_idle("t2_idle");
    check("t2_done",   done_cnt - d0, 32'd1);
    check("t4_sticky", {31'd0, Err}, 32'd1);
    check("t2_left",   exp_q.size(), 32'd0);

    // Len=2 with a third result that must be dropped
    d0 = done_cnt;
    start_tile(16'd2, 32'h200, 3, 2);
    check("t5_err_clr", {31'd0, Err}, 32'd0);
    wait_idle("t5_idle");
    check("t5_done", done_cnt - d0, 32'd1);
    check("t5_err",  {31'd0, Err}, 32'd1);
    check("t5_left", exp_q.size(), 32'd0);

    // Len=0: Done next cycle, never busy
    d0 = done_cnt;
    pe_en = 1'b0;
    Start = 1'b1; Len = 16'd0;
    tick();
    Start = 1'b0;
    check("t6_done", {31'd0, Done}, 32'd1);
    check("t6_busy", {31'd0, Busy}, 32'd0);
    tick();
    check("t6_done_end", {31'd0, Done}, 32'd0);
    check("t6_busy_end", {31'd0, Busy}, 32'd0);
    check("t6_done_cnt", done_cnt - d0, 32'd1);

    // Reset mid-collect with 5 words buffered
    DataOutRdy = 1'b0;
    start_tile(16'd8, 32'h300, 5, 5);
    repeat (20) tick();
    check("t7_busy", {31'd0, Busy}, 32'd1);
    check("t7_dov",  {31'd0, DataOutValid}, 32'd1);
    check("t7_head", DataOut, 32'h300);
    #2;
    aclr = 1'b0;
    #1;
    check("t7_rst_busy", {31'd0, Busy}, 32'd0);
    check("t7_rst_done", {31'd0, Done}, 32'd0);
    check("t7_rst_err",  {31'd0, Err}, 32'd0);
    check("t7_rst_rdy",  {31'd0, PE_DataInRdy}, 32'd0);
    check("t7_rst_dov",  {31'd0, DataOutValid}, 32'd0);
    check("t7_rst_dout", DataOut, 32'd0);
    exp_q.delete();
    pe_en = 1'b0;
    for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
    PE_DataInValid = 1'b0;
    repeat (2) tick();
    aclr = 1'b1;
    repeat (2) tick();
    check("t7_post_busy", {31'd0, Busy}, 32'd0);
    check("t7_post_dov",  {31'd0, DataOutValid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
